// File: rtl/alarm_sequencer.sv
// Alarm sequencer: arms on the alarm switch and rings when the time reaches the setpoint.
// Supports a limited number of snoozes per alarm event, plus a ring timeout and a stop button.
module alarm_sequencer #(
    parameter int unsigned RING_TIMEOUT_S = 60,
    parameter int unsigned SNOOZE_S       = 300,
    parameter int unsigned MAX_SNOOZES    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [3:0] cur_sec_lo,
    input  logic [2:0] cur_sec_hi,
    input  logic [3:0] cur_min_lo,
    input  logic [2:0] cur_min_hi,
    input  logic [3:0] alm_sec_lo,
    input  logic [2:0] alm_sec_hi,
    input  logic [3:0] alm_min_lo,
    input  logic [2:0] alm_min_hi,
    input  logic       alarmsw,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       play,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] snooze_cnt,
    output logic [8:0] snooze_left
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] RINGING = 2'd2;
    localparam logic [1:0] SNOOZE  = 2'd3;

    localparam logic [7:0] RING_LAST   = 8'(RING_TIMEOUT_S - 1);
    localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_S);
    localparam logic [1:0] CNT_MAX     = 2'(MAX_SNOOZES);

    function automatic logic time_match(
        input logic [3:0] c_sl, input logic [2:0] c_sh,
        input logic [3:0] c_ml, input logic [2:0] c_mh,
        input logic [3:0] a_sl, input logic [2:0] a_sh,
        input logic [3:0] a_ml, input logic [2:0] a_mh
    );
        return (c_sl == a_sl) && (c_sh == a_sh) && (c_ml == a_ml) && (c_mh == a_mh);
    endfunction

    logic [1:0] state_r;
    logic [1:0] next_state_s;
    logic [7:0] ring_tmr_r;
    logic [7:0] ring_tmr_s;
    logic [8:0] snz_tmr_r;
    logic [8:0] snz_tmr_s;
    logic [1:0] cnt_s;
    logic       match_s;
    logic       match_q_r;
    logic       snooze_q_r;
    logic       stop_q_r;
    logic       match_rise_s;
    logic       snooze_rise_s;
    logic       stop_rise_s;

    assign match_s       = time_match(cur_sec_lo, cur_sec_hi, cur_min_lo, cur_min_hi,
                                      alm_sec_lo, alm_sec_hi, alm_min_lo, alm_min_hi);
    assign match_rise_s  = match_s & ~match_q_r;
    assign snooze_rise_s = snooze_btn & ~snooze_q_r;
    assign stop_rise_s   = stop_btn & ~stop_q_r;

    // Next-state and timer logic; branch order encodes the event priority.
    always_comb begin
        next_state_s = state_r;
        ring_tmr_s   = ring_tmr_r;
        snz_tmr_s    = snz_tmr_r;
        cnt_s        = snooze_cnt;
        if (!alarmsw) begin
            next_state_s = IDLE;
            ring_tmr_s   = 8'd0;
            snz_tmr_s    = 9'd0;
            cnt_s        = 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    next_state_s = ARMED;
                    ring_tmr_s   = 8'd0;
                    snz_tmr_s    = 9'd0;
                    cnt_s        = 2'd0;
                end
                ARMED: begin
                    ring_tmr_s = 8'd0;
                    snz_tmr_s  = 9'd0;
                    if (match_rise_s) begin
                        next_state_s = RINGING;
                    end else begin
                        next_state_s = ARMED;
                    end
                end
                RINGING: begin
                    if (stop_rise_s || (snooze_rise_s && (snooze_cnt >= CNT_MAX))) begin
                        next_state_s = ARMED;
                        cnt_s        = 2'd0;
                        ring_tmr_s   = 8'd0;
                    end else if (snooze_rise_s) begin
                        next_state_s = SNOOZE;
                        cnt_s        = snooze_cnt + 2'd1;
                        snz_tmr_s    = SNOOZE_LOAD;
                        ring_tmr_s   = 8'd0;
                    end else if (tick_1hz) begin
                        // Terminal count is checked before incrementing, so the timer never wraps.
                        if (ring_tmr_r >= RING_LAST) begin
                            next_state_s = ARMED;
                            cnt_s        = 2'd0;
                            ring_tmr_s   = 8'd0;
                        end else begin
                            ring_tmr_s = ring_tmr_r + 8'd1;
                        end
                    end else begin
                        ring_tmr_s = ring_tmr_r;
                    end
                end
                SNOOZE: begin
                    if (stop_rise_s) begin
                        next_state_s = ARMED;
                        cnt_s        = 2'd0;
                        snz_tmr_s    = 9'd0;
                    end else if (tick_1hz) begin
                        if (snz_tmr_r <= 9'd1) begin
                            next_state_s = RINGING;
                            ring_tmr_s   = 8'd0;
                            snz_tmr_s    = 9'd0;
                        end else begin
                            snz_tmr_s = snz_tmr_r - 9'd1;
                        end
                    end else begin
                        snz_tmr_s = snz_tmr_r;
                    end
                end
                default: begin
                    next_state_s = IDLE;
                    ring_tmr_s   = 8'd0;
                    snz_tmr_s    = 9'd0;
                    cnt_s        = 2'd0;
                end
            endcase
        end
    end

    // State, edge-detect history and registered outputs; outputs are loaded from next-state values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            ring_tmr_r  <= 8'd0;
            snz_tmr_r   <= 9'd0;
            match_q_r   <= 1'b1;
            snooze_q_r  <= 1'b1;
            stop_q_r    <= 1'b1;
            play        <= 1'b0;
            ringing     <= 1'b0;
            snoozing    <= 1'b0;
            snooze_cnt  <= 2'd0;
            snooze_left <= 9'd0;
        end else begin
            state_r     <= next_state_s;
            ring_tmr_r  <= ring_tmr_s;
            snz_tmr_r   <= snz_tmr_s;
            match_q_r   <= match_s;
            snooze_q_r  <= snooze_btn;
            stop_q_r    <= stop_btn;
            play        <= (next_state_s == RINGING);
            ringing     <= (next_state_s == RINGING);
            snoozing    <= (next_state_s == SNOOZE);
            snooze_cnt  <= cnt_s;
            snooze_left <= (next_state_s == SNOOZE) ? snz_tmr_s : 9'd0;
        end
    end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: directed scenarios followed by randomized stimulus,
// both compared every cycle against a seconds-based behavioural model.
module tb_alarm_sequencer;

    localparam int RT = 5;
    localparam int SS = 3;
    localparam int MS = 2;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RING  = 2;
    localparam int M_SNZ   = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic [3:0] cur_sec_lo;
    logic [2:0] cur_sec_hi;
    logic [3:0] cur_min_lo;
    logic [2:0] cur_min_hi;
    logic [3:0] alm_sec_lo;
    logic [2:0] alm_sec_hi;
    logic [3:0] alm_min_lo;
    logic [2:0] alm_min_hi;
    logic       alarmsw;
    logic       snooze_btn;
    logic       stop_btn;
    logic       play;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_cnt;
    logic [8:0] snooze_left;

    int total = 0;
    int bad   = 0;

    int m_mode;
    int m_used;
    int m_ring_elapsed;
    int m_snz_rem;
    bit m_prev_match;
    bit m_prev_snz;
    bit m_prev_stop;

    int al_m;
    int al_s;

    always #5 clk = ~clk;

    alarm_sequencer #(
        .RING_TIMEOUT_S(RT),
        .SNOOZE_S      (SS),
        .MAX_SNOOZES   (MS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .cur_sec_lo (cur_sec_lo),
        .cur_sec_hi (cur_sec_hi),
        .cur_min_lo (cur_min_lo),
        .cur_min_hi (cur_min_hi),
        .alm_sec_lo (alm_sec_lo),
        .alm_sec_hi (alm_sec_hi),
        .alm_min_lo (alm_min_lo),
        .alm_min_hi (alm_min_hi),
        .alarmsw    (alarmsw),
        .snooze_btn (snooze_btn),
        .stop_btn   (stop_btn),
        .play       (play),
        .ringing    (ringing),
        .snoozing   (snoozing),
        .snooze_cnt (snooze_cnt),
        .snooze_left(snooze_left)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clock_secs(input int mh, input int ml, input int sh, input int sl);
        return (mh * 10 + ml) * 60 + sh * 10 + sl;
    endfunction

    task automatic model_reset();
        m_mode         = M_IDLE;
        m_used         = 0;
        m_ring_elapsed = 0;
        m_snz_rem      = 0;
        m_prev_match   = 1'b1;
        m_prev_snz     = 1'b1;
        m_prev_stop    = 1'b1;
    endtask

    // Behavioural model: elapsed ring seconds count up, snooze seconds count down to zero.
    task automatic model_step();
        bit m_now;
        bit mr;
        bit sr;
        bit tr;
        if (reset) begin
            model_reset();
        end else begin
            m_now = (clock_secs(int'(cur_min_hi), int'(cur_min_lo), int'(cur_sec_hi), int'(cur_sec_lo)) ==
                     clock_secs(int'(alm_min_hi), int'(alm_min_lo), int'(alm_sec_hi), int'(alm_sec_lo)));
            mr = m_now && !m_prev_match;
            sr = snooze_btn && !m_prev_snz;
            tr = stop_btn && !m_prev_stop;
            m_prev_match = m_now;
            m_prev_snz   = snooze_btn;
            m_prev_stop  = stop_btn;
            if (!alarmsw) begin
                m_mode = M_IDLE; m_used = 0; m_ring_elapsed = 0; m_snz_rem = 0;
            end else if (m_mode == M_IDLE) begin
                m_mode = M_ARMED;
            end else if (m_mode == M_ARMED) begin
                if (mr) begin
                    m_mode = M_RING; m_ring_elapsed = 0;
                end
            end else if (m_mode == M_RING) begin
                if (tr || (sr && m_used == MS)) begin
                    m_mode = M_ARMED; m_used = 0;
                end else if (sr) begin
                    m_mode = M_SNZ; m_used = m_used + 1; m_snz_rem = SS;
                end else if (tick_1hz) begin
                    m_ring_elapsed = m_ring_elapsed + 1;
                    if (m_ring_elapsed == RT) begin
                        m_mode = M_ARMED; m_used = 0;
                    end
                end
            end else begin
                if (tr) begin
                    m_mode = M_ARMED; m_used = 0;
                end else if (tick_1hz) begin
                    m_snz_rem = m_snz_rem - 1;
                    if (m_snz_rem == 0) begin
                        m_mode = M_RING; m_ring_elapsed = 0;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_value("play",        play,        (m_mode == M_RING) ? 1 : 0);
        check_value("ringing",     ringing,     (m_mode == M_RING) ? 1 : 0);
        check_value("snoozing",    snoozing,    (m_mode == M_SNZ) ? 1 : 0);
        check_value("snooze_cnt",  snooze_cnt,  m_used);
        check_value("snooze_left", snooze_left, (m_mode == M_SNZ) ? m_snz_rem : 0);
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        step();
    endtask

    task automatic set_time(input int m, input int s);
        cur_min_hi = 3'(m / 10);
        cur_min_lo = 4'(m % 10);
        cur_sec_hi = 3'(s / 10);
        cur_sec_lo = 4'(s % 10);
    endtask

    task automatic set_alarm(input int m, input int s);
        al_m = m;
        al_s = s;
        alm_min_hi = 3'(m / 10);
        alm_min_lo = 4'(m % 10);
        alm_sec_hi = 3'(s / 10);
        alm_sec_lo = 4'(s % 10);
    endtask

    task automatic retrigger();
        set_time(0, 11);
        step();
        set_time(0, 10);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; tick_1hz = 1'b0; alarmsw = 1'b0;
        snooze_btn = 1'b0; stop_btn = 1'b0;
        set_alarm(0, 10);
        set_time(0, 9);
        model_reset();
        step();
        step();
        check_value("rst_play", play, 0);
        check_value("rst_left", snooze_left, 0);

        // Basic ring and timeout
        reset = 1'b0; alarmsw = 1'b1;
        step();
        step();
        set_time(0, 10);
        step();
        check_value("ring_start", play, 1);
        for (int i = 1; i <= RT; i++) begin
            tick();
            if (i == RT - 1) check_value("ring_before_timeout", play, 1);
        end
        check_value("ring_timeout", play, 0);

        // Snooze countdown and return to ringing
        retrigger();
        check_value("ring2", play, 1);
        snooze_btn = 1'b1; step();
        check_value("snz_on", snoozing, 1);
        check_value("snz_cnt1", snooze_cnt, 1);
        check_value("snz_left3", snooze_left, 3);
        snooze_btn = 1'b0; step();
        tick(); check_value("snz_left2", snooze_left, 2);
        tick(); check_value("snz_left1", snooze_left, 1);
        tick(); check_value("snz_back_ring", play, 1);

        // Snooze limit reached acts as stop
        snooze_btn = 1'b1; step(); snooze_btn = 1'b0; step();
        check_value("snz_cnt2", snooze_cnt, 2);
        tick(); tick(); tick();
        check_value("ring_after_2", play, 1);
        snooze_btn = 1'b1; step();
        check_value("limit_play", play, 0);
        check_value("limit_snz", snoozing, 0);
        check_value("limit_cnt", snooze_cnt, 0);
        snooze_btn = 1'b0; step();

        // Stop and snooze together: stop wins
        retrigger();
        stop_btn = 1'b1; snooze_btn = 1'b1; step();
        check_value("both_snz", snoozing, 0);
        check_value("both_play", play, 0);
        check_value("both_cnt", snooze_cnt, 0);
        stop_btn = 1'b0; snooze_btn = 1'b0; step();

        // alarmsw dropped in snooze, then re-enabled while time still matches
        retrigger();
        snooze_btn = 1'b1; step(); snooze_btn = 1'b0; step();
        check_value("sw_snz", snoozing, 1);
        alarmsw = 1'b0; step();
        check_value("sw_off_snz", snoozing, 0);
        check_value("sw_off_cnt", snooze_cnt, 0);
        check_value("sw_off_left", snooze_left, 0);
        alarmsw = 1'b1; step(); step(); step();
        check_value("sw_on_noring", play, 0);
        retrigger();
        check_value("sw_on_ring", play, 1);

        // Async reset mid-ring with stop held
        #2;
        reset = 1'b1; stop_btn = 1'b1;
        model_reset();
        #1;
        check_value("async_rst_play", play, 0);
        step(); step();
        reset = 1'b0;
        step(); step(); step();
        check_value("post_rst_noring", play, 0);
        retrigger();
        check_value("stop_held_ring", play, 1);
        step(); step();
        check_value("stop_held_no_edge", play, 1);
        stop_btn = 1'b0; step();
        stop_btn = 1'b1; step(); stop_btn = 1'b0; step();
        check_value("stop_edge", play, 0);

        // Setpoint change in ARMED creates the match
        set_time(0, 20); step();
        set_alarm(0, 20); step();
        check_value("setpoint_ring", play, 1);
        stop_btn = 1'b1; step(); stop_btn = 1'b0; step();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            reset    = ($urandom_range(0, 999) == 0);
            alarmsw  = ($urandom_range(0, 149) != 0);
            tick_1hz = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) snooze_btn = ~snooze_btn;
            if ($urandom_range(0, 24) == 0) stop_btn = ~stop_btn;
            if ($urandom_range(0, 199) == 0) set_alarm($urandom_range(0, 59), $urandom_range(0, 59));
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 0) set_time(al_m, al_s);
                else set_time(al_m, (al_s + 1) % 60);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
  RING_TIMEOUT_S, 60, seconds of ringing before automatic silence
  SNOOZE_S, 300, snooze length in seconds (1..511)
  MAX_SNOOZES, 3, snoozes allowed per alarm event (1..3)
REQ-002 Ports SHALL be as follows, one per line: name direction width meaning.
  clk  in  1  system clock; the block has one clock only
  reset  in  1  asynchronous, active-high reset
  tick_1hz  in  1  one-cycle pulse per second from the 1 Hz generator
  cur_sec_lo  in  4  current time, seconds ones digit (BCD)
  cur_sec_hi  in  3  current time, seconds tens digit (BCD)
  cur_min_lo  in  4  current time, minutes ones digit (BCD)
  cur_min_hi  in  3  current time, minutes tens digit (BCD)
  alm_sec_lo  in  4  alarm setpoint, seconds ones digit
  alm_sec_hi  in  3  alarm setpoint, seconds tens digit
  alm_min_lo  in  4  alarm setpoint, minutes ones digit
  alm_min_hi  in  3  alarm setpoint, minutes tens digit
  alarmsw  in  1  alarm enable switch, level
  snooze_btn  in  1  debounced, synchronous snooze button, level
  stop_btn  in  1  debounced, synchronous stop button, level
  play  out  1  song request to the song player; 1 = play
  ringing  out  1  1 while in RINGING
  snoozing  out  1  1 while in SNOOZE
  snooze_cnt  out  2  snoozes used in the current alarm event
  snooze_left  out  9  seconds remaining in SNOOZE; 0 otherwise
REQ-003 All outputs SHALL be driven from registers, with no combinational path from any input to any output.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, ARMED, RINGING and SNOOZE.
REQ-005 match SHALL be asserted when all four current-time digits equal the corresponding alarm-setpoint digits.
REQ-006 match_q SHALL be the value of match registered on the previous cycle.
REQ-007 match_rise SHALL be defined as match & ~match_q.
REQ-008 snooze_rise and stop_rise SHALL be rising edges of snooze_btn and stop_btn, each detected against a registered copy of its button.
REQ-009 Transitions SHALL be evaluated every cycle in this priority order, highest first: alarmsw=0; stop_rise; snooze_rise; timer expiry; match_rise.
REQ-010 In any state, alarmsw=0 SHALL move the FSM to IDLE on the next edge, clearing snooze_cnt and all timers.
REQ-011 IDLE SHALL move to ARMED on the next edge when alarmsw=1.
REQ-012 ARMED SHALL move to RINGING on match_rise, with the ring timer cleared to 0.
REQ-013 ARMED SHALL ignore snooze_rise and stop_rise.
REQ-014 In RINGING, stop_rise SHALL move the FSM to ARMED and clear snooze_cnt.
REQ-015 In RINGING, snooze_rise with snooze_cnt < MAX_SNOOZES SHALL move the FSM to SNOOZE, increment snooze_cnt and load the snooze timer with SNOOZE_S.
REQ-016 In RINGING, snooze_rise with snooze_cnt == MAX_SNOOZES SHALL be treated as stop_rise.
REQ-017 In RINGING, the ring timer SHALL increment on each tick_1hz.
REQ-018 In RINGING, a tick_1hz while the ring timer equals RING_TIMEOUT_S-1 SHALL move the FSM to ARMED and clear snooze_cnt, so ringing lasts exactly RING_TIMEOUT_S ticks.
REQ-019 In SNOOZE, the snooze timer SHALL decrement on each tick_1hz.
REQ-020 In SNOOZE, a tick_1hz while the snooze timer equals 1 SHALL move the FSM to RINGING, clear the ring timer and leave snooze_cnt unchanged.
REQ-021 In SNOOZE, stop_rise SHALL move the FSM to ARMED and clear snooze_cnt.
REQ-022 In SNOOZE, snooze_rise SHALL be ignored.
REQ-023 match_rise SHALL be ignored in IDLE, RINGING and SNOOZE.
REQ-024 A tick_1hz arriving in the same cycle as a state change SHALL not be counted by the timer of the new state.
REQ-025 play SHALL equal 1 exactly when the registered state is RINGING.
REQ-026 play, ringing and snoozing SHALL change one cycle after the triggering event.
REQ-027 snooze_left SHALL equal the snooze timer value in SNOOZE and 0 in every other state.
REQ-028 The ring timer SHALL be 8 bits wide and the snooze timer 9 bits wide.
REQ-029 The ring timer and snooze timer SHALL never wrap.
REQ-030 A change to the alarm setpoint while in ARMED that makes match go high SHALL trigger RINGING through match_rise.

Reset
REQ-031 Reset SHALL be asynchronous and active-high.
REQ-032 While reset is high, the FSM SHALL be IDLE and play, ringing, snoozing, snooze_cnt, snooze_left and both timers SHALL be 0.
REQ-033 Reset SHALL force match_q to 1 and both button-edge registers to 1, so no edge is detected on the first cycle after reset.
REQ-034 Reset asserted in RINGING or SNOOZE SHALL drop play to 0 immediately, without waiting for a clock edge.

Verification
REQ-035 The bench SHALL use RING_TIMEOUT_S=5, SNOOZE_S=3 and MAX_SNOOZES=2 and cover the scenarios in REQ-036 to REQ-041.
REQ-036 Scenario: alarmsw=1, setpoint 00:10, time counts 00:09 -> 00:10 -> play=1 one cycle after the time reaches 00:10; play=0 after exactly 5 ticks; state ARMED.
REQ-037 Scenario: ringing, then snooze_rise -> snoozing=1, snooze_cnt=1, snooze_left=3; snooze_left counts 3, 2, 1; on the 3rd tick play=1 again.
REQ-038 Scenario: ringing after 2 snoozes, then snooze_rise -> play=0, state ARMED, snooze_cnt=0.
REQ-039 Scenario: stop_rise and snooze_rise in the same cycle while ringing -> ARMED, snooze_cnt=0, stop takes priority.
REQ-040 Scenario: alarmsw dropped to 0 in SNOOZE -> IDLE next cycle, all outputs 0; alarmsw back to 1 with time still equal to setpoint -> no ring until the next match_rise.
REQ-041 Scenario: reset pulsed mid-RINGING with stop_btn held high -> play=0 asynchronously, IDLE after release, no stop edge detected.
